// File: rtl/lfsr_pkg.sv
// Shared constants and the single-shift helper for the parametrised Fibonacci LFSR.
package lfsr_pkg;

  localparam int unsigned MAX_W = 64;
  localparam logic [31:0] LFSR_TAPS32 = 32'hB89ADA1C;
  localparam logic [31:0] LFSR_SEED32 = 32'hAAAAAAAA;

  // One Fibonacci shift of a zero-extended state; result is masked to 'width' bits.
  function automatic logic [MAX_W-1:0] lfsr_shift(input logic [MAX_W-1:0] state,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int unsigned      width);
    logic             fb;
    logic [MAX_W-1:0] mask;
    fb   = ^(state & taps);
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    return ((state << 1) | MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_pulse_cnt.sv
// Saturating pulse counter; a synchronous clear wins over a simultaneous increment.
module lfsr_pulse_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_pulse_gen.sv
// Fibonacci LFSR with runtime seed load, all-zero lockup recovery and a
// threshold-driven Bernoulli pulse plus saturating pulse counter.
module lfsr_pulse_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned     WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS32),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED32),
  parameter int unsigned     STEP  = 1,
  parameter int unsigned     CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] threshold,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic             pulse,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             zero_fix
);

  if (WIDTH < 3 || WIDTH > MAX_W || STEP < 1 || STEP > WIDTH || SEED == '0) begin : g_bad_param
    $error("lfsr_pulse_gen: illegal WIDTH/STEP/SEED parameter");
  end

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] q_n;
  logic             pulse_n;
  logic             zero_fix_n;

  // STEP single shifts unrolled into one combinational advance.
  always_comb begin
    nxt = q;
    for (int unsigned i = 0; i < STEP; i++) begin
      nxt = WIDTH'(lfsr_shift(MAX_W'(nxt), MAX_W'(TAPS), WIDTH));
    end
  end

  // Next-state selection: seed_load > ce > hold; pulse only on an advance.
  always_comb begin
    q_n        = q;
    pulse_n    = 1'b0;
    zero_fix_n = zero_fix;
    if (seed_load) begin
      if (seed == '0) begin
        q_n        = SEED;
        zero_fix_n = 1'b1;
      end else begin
        q_n = seed;
      end
    end else if (ce) begin
      if (nxt == '0) begin
        q_n        = SEED;
        zero_fix_n = 1'b1;
      end else begin
        q_n = nxt;
      end
      pulse_n = (q_n < threshold);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= SEED;
      pulse    <= 1'b0;
      zero_fix <= 1'b0;
    end else begin
      q        <= q_n;
      pulse    <= pulse_n;
      zero_fix <= zero_fix_n;
    end
  end

  lfsr_pulse_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (pulse_n),
    .cnt (pulse_cnt)
  );

endmodule

// File: tb/tb_lfsr_pulse_gen.sv
// Directed bench: default 32-bit instance, a CNT_W=4 twin sharing its stimulus,
// and a WIDTH=16/STEP=8 instance checked against a hand-coded 16-bit reference.
module tb_lfsr_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, seed_load, cnt_clr;
  logic [31:0] seed, threshold;

  logic [31:0] a_q;
  logic        a_pulse, a_zf;
  logic [15:0] a_cnt;

  logic [31:0] b_q;
  logic        b_pulse, b_zf;
  logic [3:0]  b_cnt;

  logic        c_ce, c_seed_load, c_cnt_clr;
  logic [15:0] c_seed, c_thr;
  logic [15:0] c_q;
  logic        c_pulse, c_zf;
  logic [15:0] c_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_pulse_gen u_a (
    .clk(clk), .rst(rst), .ce(ce), .seed_load(seed_load), .seed(seed),
    .threshold(threshold), .cnt_clr(cnt_clr),
    .q(a_q), .pulse(a_pulse), .pulse_cnt(a_cnt), .zero_fix(a_zf)
  );

  lfsr_pulse_gen #(.CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .ce(ce), .seed_load(seed_load), .seed(seed),
    .threshold(threshold), .cnt_clr(cnt_clr),
    .q(b_q), .pulse(b_pulse), .pulse_cnt(b_cnt), .zero_fix(b_zf)
  );

  lfsr_pulse_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hAAAA), .STEP(8)) u_c (
    .clk(clk), .rst(rst), .ce(c_ce), .seed_load(c_seed_load), .seed(c_seed),
    .threshold(c_thr), .cnt_clr(c_cnt_clr),
    .q(c_q), .pulse(c_pulse), .pulse_cnt(c_cnt), .zero_fix(c_zf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Taps 0xB400 = bits 15,13,12,10.
  function automatic logic [15:0] ref_shift16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  initial begin
    logic        seen;
    logic        moved;
    logic [15:0] m;

    rst = 1'b1; ce = 1'b0; seed_load = 1'b0; cnt_clr = 1'b0;
    seed = '0; threshold = '0;
    c_ce = 1'b0; c_seed_load = 1'b0; c_cnt_clr = 1'b0; c_seed = '0; c_thr = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_q", a_q, 64'hAAAAAAAA);
    check("rst_pulse", a_pulse, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_zf", a_zf, 0);
    check("rst_q16", c_q, 64'hAAAA);

    // Idle hold for 50 cycles.
    seen = 1'b0; moved = 1'b0;
    repeat (50) begin
      tick();
      if (a_pulse) seen = 1'b1;
      if (a_q != 32'hAAAAAAAA) moved = 1'b1;
    end
    check("idle_moved", moved, 0);
    check("idle_pulse", seen, 0);

    ce = 1'b1; tick();
    check("one_step", a_q, 64'h55555554);

    seed_load = 1'b1; seed = 32'h12345678; tick();
    check("load_q", a_q, 64'h12345678);
    check("load_pulse", a_pulse, 0);
    ce = 1'b0;

    seed = 32'h0; tick();
    check("load0_q", a_q, 64'hAAAAAAAA);
    check("load0_zf", a_zf, 1);
    seed = 32'h1; tick();
    check("load1_q", a_q, 64'h1);
    check("zf_sticky", a_zf, 1);
    seed_load = 1'b0;

    // threshold = 0: no pulses at all.
    threshold = 32'h0; ce = 1'b1; seen = 1'b0;
    repeat (1000) begin
      tick();
      if (a_pulse) seen = 1'b1;
    end
    check("thr0_pulse", seen, 0);
    check("thr0_cnt", a_cnt, 0);

    // threshold = all-ones: every step pulses; 4-bit twin saturates.
    ce = 1'b0; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    threshold = 32'hFFFFFFFF; ce = 1'b1;
    repeat (1000) tick();
    ce = 1'b0; tick();
    check("full_cnt", a_cnt, 1000);
    check("sat_cnt", b_cnt, 15);
    check("idle_pulse_low", a_pulse, 0);

    ce = 1'b1; cnt_clr = 1'b1; tick();
    check("clr_pulse", a_pulse, 1);
    check("clr_cnt", a_cnt, 0);
    cnt_clr = 1'b0; tick();
    check("after_clr_cnt", a_cnt, 1);
    ce = 1'b0;

    // 0x7FFFFFFF shifts to all-ones (15 taps hit, fb=1): no pulse then.
    seed_load = 1'b1; seed = 32'h7FFFFFFF; tick(); seed_load = 1'b0;
    ce = 1'b1; tick();
    check("allones_q", a_q, 64'hFFFFFFFF);
    check("allones_pulse", a_pulse, 0);

    // Half probability over 10000 steps.
    ce = 1'b0; cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    threshold = 32'h80000000; ce = 1'b1;
    repeat (10000) tick();
    check("half_range", (a_cnt >= 16'd4700 && a_cnt <= 16'd5300), 1);

    // Asynchronous reset mid-cycle, observed before the next edge.
    c_ce = 1'b1;
    tick();
    #3 rst = 1'b1;
    #1;
    check("async_q", a_q, 64'hAAAAAAAA);
    check("async_cnt", a_cnt, 0);
    check("async_zf", a_zf, 0);
    check("async_q16", c_q, 64'hAAAA);
    ce = 1'b0; c_ce = 1'b0;
    tick();
    rst = 1'b0;

    // 16-bit, 8 shifts per enable.
    m = 16'hAAAA;
    c_ce = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int j = 0; j < 8; j++) m = ref_shift16(m);
      check($sformatf("step8_%0d", k), c_q, m);
    end
    c_ce = 1'b0;
    check("step8_zf", c_zf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
